// File: rtl/addr_map_pkg.sv
// Shared types and the reset-time address map for addr_map_ctrl.
// The default table mirrors the SoC memory map; rule n routes to target port n.
package addr_map_pkg;

    localparam int unsigned NumDefaultRules = 13;

    typedef enum logic [1:0] {
        CfgStart = 2'd0,
        CfgEnd   = 2'd1,
        CfgIdx   = 2'd2,
        CfgCtrl  = 2'd3
    } cfg_field_e;

    typedef struct packed {
        logic [63:0] start;
        logic [63:0] end_addr;
        logic [7:0]  idx;
        logic        valid;
        logic        lock;
    } rule_t;

    // end_addr is exclusive
    localparam rule_t DefaultRules [NumDefaultRules] = '{
        '{start: 64'h0000_0000, end_addr: 64'h0000_1000, idx: 8'd0,  valid: 1'b1, lock: 1'b0}, // Debug
        '{start: 64'h0001_0000, end_addr: 64'h0002_0000, idx: 8'd1,  valid: 1'b1, lock: 1'b0}, // ROM
        '{start: 64'h0200_0000, end_addr: 64'h0204_0000, idx: 8'd2,  valid: 1'b1, lock: 1'b0}, // CLINT
        '{start: 64'h0400_0000, end_addr: 64'h0800_0000, idx: 8'd3,  valid: 1'b1, lock: 1'b0}, // PLIC
        '{start: 64'h0300_0000, end_addr: 64'h0300_1000, idx: 8'd4,  valid: 1'b1, lock: 1'b0}, // Regs
        '{start: 64'h1C00_0000, end_addr: 64'h1C10_0000, idx: 8'd5,  valid: 1'b1, lock: 1'b0}, // SPM
        '{start: 64'h0300_2000, end_addr: 64'h0300_3000, idx: 8'd6,  valid: 1'b1, lock: 1'b0}, // UART
        '{start: 64'h0300_3000, end_addr: 64'h0300_4000, idx: 8'd7,  valid: 1'b1, lock: 1'b0}, // I2C
        '{start: 64'h0300_4000, end_addr: 64'h0300_5000, idx: 8'd8,  valid: 1'b1, lock: 1'b0}, // SPI
        '{start: 64'h0300_5000, end_addr: 64'h0300_6000, idx: 8'd9,  valid: 1'b1, lock: 1'b0}, // GPIO
        '{start: 64'h0300_6000, end_addr: 64'h0300_7000, idx: 8'd10, valid: 1'b1, lock: 1'b0}, // SLINK
        '{start: 64'h0300_7000, end_addr: 64'h0300_8000, idx: 8'd11, valid: 1'b1, lock: 1'b0}, // VGA
        '{start: 64'h8000_0000, end_addr: 64'hA000_0000, idx: 8'd12, valid: 1'b1, lock: 1'b0}  // HYAXI
    };

endpackage

// File: rtl/addr_map_if.sv
// Config and lookup handshake bundle for addr_map_ctrl; master is the requester side.
interface addr_map_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = 4,
    parameter int unsigned SelW      = 6
);
    logic                 cfg_req;
    logic                 cfg_we;
    logic [SelW-1:0]      cfg_sel;
    logic [63:0]          cfg_wdata;
    logic                 cfg_gnt;
    logic                 cfg_rvalid;
    logic                 cfg_err;
    logic [63:0]          cfg_rdata;
    logic                 lk_valid;
    logic [AddrWidth-1:0] lk_addr;
    logic                 lk_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [IdxWidth-1:0]  res_idx;
    logic                 res_decerr;

    modport master (
        output cfg_req, cfg_we, cfg_sel, cfg_wdata, lk_valid, lk_addr, res_ready,
        input  cfg_gnt, cfg_rvalid, cfg_err, cfg_rdata, lk_ready, res_valid, res_idx, res_decerr
    );

    modport slave (
        input  cfg_req, cfg_we, cfg_sel, cfg_wdata, lk_valid, lk_addr, res_ready,
        output cfg_gnt, cfg_rvalid, cfg_err, cfg_rdata, lk_ready, res_valid, res_idx, res_decerr
    );
endinterface

// File: rtl/addr_map_match.sv
// Combinational priority matcher: lowest-numbered valid rule with start <= addr < end wins.
module addr_map_match #(
    parameter int unsigned NumRules  = 13,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = 4
) (
    input  logic [NumRules-1:0][AddrWidth-1:0] start_i,
    input  logic [NumRules-1:0][AddrWidth-1:0] end_i,
    input  logic [NumRules-1:0][IdxWidth-1:0]  idx_i,
    input  logic [NumRules-1:0]                valid_i,
    input  logic [AddrWidth-1:0]               addr_i,
    output logic [IdxWidth-1:0]                idx_o,
    output logic                               decerr_o
);
    logic [NumRules-1:0] hit;

    // end <= start can never satisfy both compares, so empty rules fall out naturally
    for (genvar g = 0; g < NumRules; g++) begin : g_hit
        assign hit[g] = valid_i[g] && (addr_i >= start_i[g]) && (addr_i < end_i[g]);
    end

    always_comb begin
        idx_o    = '0;
        decerr_o = 1'b1;
        for (int i = NumRules - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx_o    = idx_i[i];
                decerr_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/addr_map_ctrl.sv
// Programmable address map: rule table, config port and registered lookup result.
// Define ADDR_MAP_CTRL_LOCK_EN to make ctrl bit1 a sticky per-rule write lock.
module addr_map_ctrl #(
    parameter int unsigned NumRules  = 13,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxWidth  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_req_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NumRules)+1:0]  cfg_sel_i,
    input  logic [63:0]                  cfg_wdata_i,
    output logic                         cfg_gnt_o,
    output logic                         cfg_rvalid_o,
    output logic                         cfg_err_o,
    output logic [63:0]                  cfg_rdata_o,
    input  logic                         lk_valid_i,
    input  logic [AddrWidth-1:0]         lk_addr_i,
    output logic                         lk_ready_o,
    output logic                         lk_valid_o,
    input  logic                         lk_ready_i,
    output logic [IdxWidth-1:0]          lk_idx_o,
    output logic                         lk_decerr_o
);
    import addr_map_pkg::*;

    localparam int unsigned RuleW = $clog2(NumRules);

    logic [NumRules-1:0][AddrWidth-1:0] start_q, start_d, end_q, end_d, def_start, def_end;
    logic [NumRules-1:0][IdxWidth-1:0]  idx_q, idx_d, def_idx;
    logic [NumRules-1:0]                valid_q, valid_d, def_valid;
`ifdef ADDR_MAP_CTRL_LOCK_EN
    logic [NumRules-1:0]                lock_q, lock_d, def_lock;
`endif

    // Reset image; rules beyond the package table come up empty and invalid
    for (genvar g = 0; g < NumRules; g++) begin : g_def
        if (g < NumDefaultRules) begin : g_tab
            assign def_start[g] = AddrWidth'(DefaultRules[g].start);
            assign def_end[g]   = AddrWidth'(DefaultRules[g].end_addr);
            assign def_idx[g]   = IdxWidth'(DefaultRules[g].idx);
            assign def_valid[g] = DefaultRules[g].valid;
`ifdef ADDR_MAP_CTRL_LOCK_EN
            assign def_lock[g]  = DefaultRules[g].lock;
`endif
        end else begin : g_empty
            assign def_start[g] = '0;
            assign def_end[g]   = '0;
            assign def_idx[g]   = '0;
            assign def_valid[g] = 1'b0;
`ifdef ADDR_MAP_CTRL_LOCK_EN
            assign def_lock[g]  = 1'b0;
`endif
        end
    end

    logic [RuleW-1:0] rule_sel;
    cfg_field_e       field;
    logic             in_range, locked, lock_rd, wr_en;

    assign rule_sel  = cfg_sel_i[RuleW+1:2];
    assign field     = cfg_field_e'(cfg_sel_i[1:0]);
    assign in_range  = 32'(rule_sel) < NumRules;
    assign cfg_gnt_o = cfg_req_i;
`ifdef ADDR_MAP_CTRL_LOCK_EN
    assign locked  = in_range && lock_q[rule_sel];
    assign lock_rd = lock_q[rule_sel];
`else
    assign locked  = 1'b0;
    assign lock_rd = 1'b0;
`endif
    assign wr_en = cfg_req_i && cfg_we_i && in_range && !locked;

    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        idx_d   = idx_q;
        valid_d = valid_q;
`ifdef ADDR_MAP_CTRL_LOCK_EN
        lock_d  = lock_q;
`endif
        if (wr_en) begin
            case (field)
                CfgStart: start_d[rule_sel] = cfg_wdata_i[AddrWidth-1:0];
                CfgEnd:   end_d[rule_sel]   = cfg_wdata_i[AddrWidth-1:0];
                CfgIdx:   idx_d[rule_sel]   = cfg_wdata_i[IdxWidth-1:0];
                default: begin
                    valid_d[rule_sel] = cfg_wdata_i[0];
`ifdef ADDR_MAP_CTRL_LOCK_EN
                    lock_d[rule_sel]  = cfg_wdata_i[1];
`endif
                end
            endcase
        end
    end

    logic        cfg_rvalid_q, cfg_rvalid_d, cfg_err_q, cfg_err_d;
    logic [63:0] cfg_rdata_q, cfg_rdata_d;

    always_comb begin
        cfg_rvalid_d = cfg_req_i;
        cfg_err_d    = cfg_req_i && (!in_range || (cfg_we_i && locked));
        cfg_rdata_d  = '0;
        if (cfg_req_i && !cfg_we_i && in_range) begin
            case (field)
                CfgStart: cfg_rdata_d = 64'(start_q[rule_sel]);
                CfgEnd:   cfg_rdata_d = 64'(end_q[rule_sel]);
                CfgIdx:   cfg_rdata_d = 64'(idx_q[rule_sel]);
                default:  cfg_rdata_d = {62'd0, lock_rd, valid_q[rule_sel]};
            endcase
        end
    end

    logic [IdxWidth-1:0] m_idx, lk_idx_q, lk_idx_d;
    logic                m_decerr, lk_decerr_q, lk_decerr_d, lk_valid_q, lk_valid_d;

    // Matcher sees the pre-write table, so a same-cycle cfg write only affects later lookups
    addr_map_match #(
        .NumRules (NumRules),
        .AddrWidth(AddrWidth),
        .IdxWidth (IdxWidth)
    ) u_match (
        .start_i (start_q),
        .end_i   (end_q),
        .idx_i   (idx_q),
        .valid_i (valid_q),
        .addr_i  (lk_addr_i),
        .idx_o   (m_idx),
        .decerr_o(m_decerr)
    );

    assign lk_ready_o = !lk_valid_q || lk_ready_i;

    always_comb begin
        lk_valid_d  = lk_valid_q;
        lk_idx_d    = lk_idx_q;
        lk_decerr_d = lk_decerr_q;
        if (lk_valid_i && lk_ready_o) begin
            lk_valid_d  = 1'b1;
            lk_idx_d    = m_idx;
            lk_decerr_d = m_decerr;
        end else if (lk_ready_i) begin
            lk_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q      <= def_start;
            end_q        <= def_end;
            idx_q        <= def_idx;
            valid_q      <= def_valid;
`ifdef ADDR_MAP_CTRL_LOCK_EN
            lock_q       <= def_lock;
`endif
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
            lk_valid_q   <= 1'b0;
            lk_idx_q     <= '0;
            lk_decerr_q  <= 1'b0;
        end else begin
            start_q      <= start_d;
            end_q        <= end_d;
            idx_q        <= idx_d;
            valid_q      <= valid_d;
`ifdef ADDR_MAP_CTRL_LOCK_EN
            lock_q       <= lock_d;
`endif
            cfg_rvalid_q <= cfg_rvalid_d;
            cfg_err_q    <= cfg_err_d;
            cfg_rdata_q  <= cfg_rdata_d;
            lk_valid_q   <= lk_valid_d;
            lk_idx_q     <= lk_idx_d;
            lk_decerr_q  <= lk_decerr_d;
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_err_o    = cfg_err_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign lk_valid_o   = lk_valid_q;
    assign lk_idx_o     = lk_idx_q;
    assign lk_decerr_o  = lk_decerr_q;
endmodule
